// File: rtl/pay_settle.sv
// Checkout stage: latches cart total, collects coins, then returns change greedily (20/10/5/1) over valid/ready.
// Optional inactivity auto-cancel in PAY when PAY_TIMEOUT_EN is defined; chg_sel holds while chg_valid && !chg_ready.
module pay_settle #(
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] total_price,
    input  logic [3:0] total_num,
    input  logic       coin_valid,
    input  logic [1:0] coin_sel,
    input  logic       cancel,
    input  logic       chg_ready,
    output logic       busy,
    output logic [7:0] paid,
    output logic [7:0] due,
    output logic       chg_valid,
    output logic [1:0] chg_sel,
    output logic       done,
    output logic       refund,
    output logic       cart_clr,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, PAY, CHANGE, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] price_q, price_nxt;
    logic [8:0] paid_int, paid_int_nxt;
    logic [8:0] chg_amt, chg_amt_nxt;
    logic       refund_nxt;
    logic [8:0] coin_val;
    logic [8:0] sum;
    logic [1:0] chg_den;
    logic       abort;
    logic [7:0] paid_sat_nxt;
    logic [7:0] due_nxt;

    if (TIMEOUT_CYC >= (1 << CNT_W)) begin : g_cnt_w_too_small
        $error("pay_settle: CNT_W too narrow for TIMEOUT_CYC");
    end

    function automatic logic [4:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'b00:   return 5'd1;
            2'b01:   return 5'd5;
            2'b10:   return 5'd10;
            default: return 5'd20;
        endcase
    endfunction

`ifdef PAY_TIMEOUT_EN
    logic [CNT_W-1:0] idle_cnt;

    // Held at zero outside PAY, so every entry into PAY starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != PAY || coin_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state == PAY) && (idle_cnt == CNT_W'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    assign abort = (state == PAY) && (cancel || timeout);

    // Greedy denomination follows chg_amt, which only moves on a handshake, so chg_sel is stable under backpressure.
    always_comb begin
        if (chg_amt >= 9'd20) begin
            chg_den = 2'b11;
        end else if (chg_amt >= 9'd10) begin
            chg_den = 2'b10;
        end else if (chg_amt >= 9'd5) begin
            chg_den = 2'b01;
        end else begin
            chg_den = 2'b00;
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cart_clr  = done && !refund;
    assign chg_valid = (state == CHANGE) && (chg_amt != 9'd0);
    assign chg_sel   = chg_valid ? chg_den : 2'b00;

    always_comb begin
        state_nxt    = state;
        price_nxt    = price_q;
        paid_int_nxt = paid_int;
        chg_amt_nxt  = chg_amt;
        refund_nxt   = refund;
        coin_val     = {4'b0, coin_value(coin_sel)};
        sum          = paid_int + coin_val;

        case (state)
            IDLE: begin
                if (start && total_price != 8'd0 && total_num != 4'd0) begin
                    price_nxt    = total_price;
                    paid_int_nxt = 9'd0;
                    chg_amt_nxt  = 9'd0;
                    refund_nxt   = 1'b0;
                    state_nxt    = PAY;
                end
            end
            PAY: begin
                if (coin_valid) begin
                    paid_int_nxt = sum;
                end
                // Cancel beats a completing coin; that coin is refunded along with the rest.
                if (abort) begin
                    refund_nxt  = 1'b1;
                    chg_amt_nxt = coin_valid ? sum : paid_int;
                    state_nxt   = (chg_amt_nxt == 9'd0) ? DONE : CHANGE;
                end else if (coin_valid && sum >= {1'b0, price_q}) begin
                    chg_amt_nxt = sum - {1'b0, price_q};
                    state_nxt   = CHANGE;
                end
            end
            CHANGE: begin
                if (chg_amt == 9'd0) begin
                    state_nxt = DONE;
                end else if (chg_ready) begin
                    chg_amt_nxt = chg_amt - {4'b0, coin_value(chg_den)};
                end
            end
            DONE: begin
                state_nxt    = IDLE;
                refund_nxt   = 1'b0;
                paid_int_nxt = 9'd0;
                price_nxt    = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        paid_sat_nxt = paid_int_nxt[8] ? 8'hFF : paid_int_nxt[7:0];
        due_nxt      = ({1'b0, price_nxt} > paid_int_nxt) ? (price_nxt - paid_int_nxt[7:0]) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            price_q  <= 8'd0;
            paid_int <= 9'd0;
            chg_amt  <= 9'd0;
            refund   <= 1'b0;
            paid     <= 8'd0;
            due      <= 8'd0;
        end else begin
            state    <= state_nxt;
            price_q  <= price_nxt;
            paid_int <= paid_int_nxt;
            chg_amt  <= chg_amt_nxt;
            refund   <= refund_nxt;
            paid     <= paid_sat_nxt;
            due      <= due_nxt;
        end
    end

endmodule
